// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into one short/long press event per press and
// serves the per-channel single-entry event slots round-robin over a valid/ready port.
module button_event_arbiter #(
  parameter int NUM_BUTTONS = 4,
  parameter int LONG_COUNT  = 25000000,
  parameter int CNT_WIDTH   = 25,
  parameter int ID_WIDTH    = 2
) (
  input  logic                   CLK,
  input  logic                   i_RST_N,
  input  logic [NUM_BUTTONS-1:0] i_BTN,
  output logic                   o_EVT_VALID,
  output logic [ID_WIDTH-1:0]    o_EVT_ID,
  output logic                   o_EVT_LONG,
  input  logic                   i_EVT_READY,
  output logic [NUM_BUTTONS-1:0] o_OVERFLOW,
  input  logic                   i_CLR_OVF
);

  localparam logic [CNT_WIDTH-1:0] LongCnt  = CNT_WIDTH'(LONG_COUNT);
  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0]  LastInit = ID_WIDTH'(NUM_BUTTONS - 1);

  typedef enum logic {IDLE, OFFER} state_e;

  state_e                 state_q, state_d;
  logic [NUM_BUTTONS-1:0] prev_q;
  logic [NUM_BUTTONS-1:0] long_done_q, long_done_d;
  logic [NUM_BUTTONS-1:0] pend_q, pend_d;
  logic [NUM_BUTTONS-1:0] pend_long_q, pend_long_d;
  logic [NUM_BUTTONS-1:0] ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   cnt_q [NUM_BUTTONS];
  logic [CNT_WIDTH-1:0]   cnt_d [NUM_BUTTONS];
  logic [ID_WIDTH-1:0]    last_q, last_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic                   long_q, long_d;

  logic                   selFound;
  logic [ID_WIDTH-1:0]    selIdx;
  logic [NUM_BUTTONS-1:0] grantVec;
  logic [NUM_BUTTONS-1:0] postEvt;
  logic [NUM_BUTTONS-1:0] postLong;

  // Round-robin search: channels above the last served one first, then wrap.
  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!selFound && pend_q[i] && (ID_WIDTH'(i) > last_q)) begin
        selFound = 1'b1;
        selIdx   = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!selFound && pend_q[i] && (ID_WIDTH'(i) <= last_q)) begin
        selFound = 1'b1;
        selIdx   = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      grantVec[i] = (state_q == IDLE) && selFound && (selIdx == ID_WIDTH'(i));
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    long_done_d = long_done_q;
    pend_d      = pend_q;
    pend_long_d = pend_long_q;
    ovf_d       = i_CLR_OVF ? '0 : ovf_q;
    postEvt     = '0;
    postLong    = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (i_BTN[i] && !prev_q[i]) begin
        cnt_d[i]       = CntOne;
        long_done_d[i] = 1'b0;
      end else if (i_BTN[i] && prev_q[i]) begin
        if (cnt_q[i] != LongCnt) begin
          cnt_d[i] = cnt_q[i] + CntOne;
          if ((cnt_q[i] + CntOne == LongCnt) && !long_done_q[i]) begin
            postEvt[i]     = 1'b1;
            postLong[i]    = 1'b1;
            long_done_d[i] = 1'b1;
          end
        end
      end else if (!i_BTN[i] && prev_q[i]) begin
        postEvt[i]     = !long_done_q[i];
        cnt_d[i]       = '0;
        long_done_d[i] = 1'b0;
      end

      // A grant on the same edge frees the slot, so the new event still fits.
      if (grantVec[i]) begin
        pend_d[i] = 1'b0;
      end
      if (postEvt[i]) begin
        if (!pend_q[i] || grantVec[i]) begin
          pend_d[i]      = 1'b1;
          pend_long_d[i] = postLong[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    long_d  = long_q;
    case (state_q)
      IDLE: begin
        if (selFound) begin
          id_d    = selIdx;
          long_d  = pend_long_q[selIdx];
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (i_EVT_READY) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_EVT_VALID = (state_q == OFFER);
    o_EVT_ID    = id_q;
    o_EVT_LONG  = long_q;
    o_OVERFLOW  = ovf_q;
  end

  always_ff @(posedge CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      prev_q      <= '0;
      long_done_q <= '0;
      pend_q      <= '0;
      pend_long_q <= '0;
      ovf_q       <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
      last_q      <= LastInit;
      id_q        <= '0;
      long_q      <= 1'b0;
    end else begin
      prev_q      <= i_BTN;
      long_done_q <= long_done_d;
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      id_q        <= id_d;
      long_q      <= long_d;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: stimulus queues expected events,
// a negedge monitor pops and compares them on every accepted handshake.
module tb_button_event_arbiter;

  logic       clock;
  logic       rstN;
  logic [3:0] btn;
  logic       evtValid;
  logic [1:0] evtId;
  logic       evtLong;
  logic       evtReady;
  logic [3:0] overflow;
  logic       clrOvf;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0] id;
    logic       isLong;
    int         riseCyc;
  } evt_t;

  evt_t expQ[$];

  button_event_arbiter #(
    .NUM_BUTTONS(4),
    .LONG_COUNT (16),
    .CNT_WIDTH  (5),
    .ID_WIDTH   (2)
  ) dut (
    .CLK        (clock),
    .i_RST_N    (rstN),
    .i_BTN      (btn),
    .o_EVT_VALID(evtValid),
    .o_EVT_ID   (evtId),
    .o_EVT_LONG (evtLong),
    .i_EVT_READY(evtReady),
    .o_OVERFLOW (overflow),
    .i_CLR_OVF  (clrOvf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Press the buttons in mask for 'hold' sampled edges, then release and let the release be sampled.
  task automatic applyStimulus(input logic [3:0] mask, input int hold);
    btn = btn | mask;
    repeat (hold) tick();
    btn = btn & ~mask;
    tick();
  endtask

  task automatic pushEvt(input logic [1:0] id, input logic isLong, input int riseCyc);
    evt_t e;
    e.id      = id;
    e.isLong  = isLong;
    e.riseCyc = riseCyc;
    expQ.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || evtValid) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("[TB] FAIL drain timeout: pending=%0d valid=%0b, required pending=0 valid=0",
               expQ.size(), evtValid);
      expQ.delete();
    end
  endtask

  // Monitor: tracks valid rise time, checks stability under backpressure, pops on acceptance.
  initial begin
    logic       prevValid;
    logic       prevReady;
    logic [1:0] prevId;
    logic       prevLong;
    int         riseCyc;
    evt_t       e;
    prevValid = 1'b0;
    prevReady = 1'b0;
    prevId    = '0;
    prevLong  = 1'b0;
    riseCyc   = 0;
    forever begin
      @(negedge clock);
      if (!rstN) begin
        prevValid = 1'b0;
        prevReady = 1'b0;
      end else begin
        if (evtValid && !prevValid) riseCyc = cyc;
        if (evtValid && prevValid && !prevReady) begin
          checkOutput("held id", 32'(evtId), 32'(prevId));
          checkOutput("held long", 32'(evtLong), 32'(prevLong));
        end
        if (evtValid && evtReady) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected event: got id=%0d long=%0b, expected none",
                     evtId, evtLong);
          end else begin
            e = expQ.pop_front();
            checkOutput("event id", 32'(evtId), 32'(e.id));
            checkOutput("event long", 32'(evtLong), 32'(e.isLong));
            if (e.riseCyc != 0) checkOutput("valid rise cycle", 32'(riseCyc), 32'(e.riseCyc));
          end
        end
        prevValid = evtValid;
        prevReady = evtReady;
        prevId    = evtId;
        prevLong  = evtLong;
      end
    end
  end

  initial begin
    rstN     = 1'b0;
    btn      = '0;
    evtReady = 1'b0;
    clrOvf   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset valid", 32'(evtValid), 32'd0);
    checkOutput("reset id", 32'(evtId), 32'd0);
    checkOutput("reset long", 32'(evtLong), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    rstN = 1'b1;
    tick();

    // Round-robin from the reset pointer: channel 0 before channel 3.
    evtReady = 1'b1;
    pushEvt(2'd0, 1'b0, 0);
    pushEvt(2'd3, 1'b0, 0);
    applyStimulus(4'b1001, 3);
    drain();

    // Serve channel 0 alone, then both again: channel 3 now comes first.
    pushEvt(2'd0, 1'b0, 0);
    applyStimulus(4'b0001, 3);
    drain();
    pushEvt(2'd3, 1'b0, 0);
    pushEvt(2'd0, 1'b0, 0);
    applyStimulus(4'b1001, 3);
    drain();

    // Short press: valid rises two edges after the low level is driven.
    pushEvt(2'd1, 1'b0, cyc + 5 + 2);
    applyStimulus(4'b0010, 5);
    drain();

    // Long press: valid rises 16 edges after the press-sampling edge.
    pushEvt(2'd2, 1'b1, cyc + 17);
    applyStimulus(4'b0100, 40);
    drain();

    // Threshold boundary: 15 sampled edges is short, 16 is long.
    pushEvt(2'd3, 1'b0, cyc + 17);
    applyStimulus(4'b1000, 15);
    drain();
    pushEvt(2'd3, 1'b1, cyc + 17);
    applyStimulus(4'b1000, 16);
    drain();

    // Backpressure: first event offered, second waits in the slot, third is dropped.
    evtReady = 1'b0;
    pushEvt(2'd1, 1'b0, 0);
    pushEvt(2'd1, 1'b0, 0);
    applyStimulus(4'b0010, 2);
    tick();
    applyStimulus(4'b0010, 2);
    applyStimulus(4'b0010, 2);
    checkOutput("backpressure valid", 32'(evtValid), 32'd1);
    checkOutput("backpressure id", 32'(evtId), 32'd1);
    checkOutput("overflow set", 32'(overflow), 32'h2);
    clrOvf = 1'b1;
    tick();
    clrOvf = 1'b0;
    checkOutput("overflow cleared", 32'(overflow), 32'd0);
    evtReady = 1'b1;
    drain();

    // Channel 2 posts on the very edge it is granted: nothing may be lost.
    evtReady = 1'b0;
    pushEvt(2'd0, 1'b0, 0);
    pushEvt(2'd2, 1'b0, 0);
    pushEvt(2'd2, 1'b0, 0);
    applyStimulus(4'b0001, 2);
    tick();
    applyStimulus(4'b0100, 2);
    btn[2] = 1'b1;
    tick();
    tick();
    evtReady = 1'b1;
    tick();
    btn[2] = 1'b0;
    tick();
    drain();
    checkOutput("same-edge overflow", 32'(overflow), 32'd0);

    // Reset while offering, with button 0 held across reset release.
    evtReady = 1'b0;
    applyStimulus(4'b0010, 2);
    tick();
    checkOutput("offer before reset", 32'(evtValid), 32'd1);
    expQ.delete();
    btn[0] = 1'b1;
    rstN   = 1'b0;
    #1;
    checkOutput("async reset valid", 32'(evtValid), 32'd0);
    checkOutput("async reset id", 32'(evtId), 32'd0);
    checkOutput("async reset long", 32'(evtLong), 32'd0);
    checkOutput("async reset overflow", 32'(overflow), 32'd0);
    tick();
    tick();
    rstN     = 1'b1;
    evtReady = 1'b1;
    tick();
    tick();
    tick();
    pushEvt(2'd0, 1'b0, cyc + 2);
    btn[0] = 1'b0;
    tick();
    drain();

    repeat (5) tick();
    checkOutput("final valid", 32'(evtValid), 32'd0);
    checkOutput("final queue", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
